blink_monitor: RTL
==================

# blink_monitor

Receive-side checker for the blink protocol: a free-running blinker emits a one-cycle `flg` pulse every 2^CBITS cycles and toggles `led` on the following cycle. `blink_monitor` samples both signals in the same clock domain, measures the pulse period, and checks `led` toggle placement. It reports lock and error status to the status/interrupt logic.

## Interface
- `CBITS`, default 8: blinker counter width; expected period P = 2^CBITS cycles.
- `LOCK_CNT`, default 2: number of consecutive good periods needed to declare lock; range 1..15.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `flg_i`  in  1: period pulse from the blinker.
- `led_i`  in  1: LED level from the blinker.
- `locked`  out  1: high while in LOCKED.
- `err`  out  1: high while in ERR.
- `err_pulse`  out  1: one-cycle strobe per detected violation.
- `period`  out  CBITS+1: last measured flg-to-flg distance in cycles, saturating.

## Operation
- Registers:
  - `gap` (CBITS+1 bits): cleared on a cycle with `flg_i`=1; otherwise increments, saturating at GMAX = 2^(CBITS+1)-1.
  - `led_q`: previous `led_i`.
  - `flg_q`: previous `flg_i`.
  - `good_cnt` (4 bits).
- On `flg_i`=1 while not in IDLE: `period` <= `gap`+1, saturating at GMAX. The period is good iff `gap` == P-1.
- LED rule: `led_i` != `led_q` is legal only when `flg_q`=1. When `flg_q`=1 and `led_i` == `led_q`, that is a violation (missing toggle). The LED rule is checked only in LOCKED.
- Timeout: in SYNC or LOCKED, `gap` reaching GMAX with no `flg_i` is a violation. Only one violation is reported per timeout; `gap` then holds until the next `flg_i`.
- Violations in one cycle (bad period, LED error, timeout) are ORed into a single `err_pulse`.
- FSM (package enum):
  - IDLE: on `flg_i` go to SYNC; `good_cnt`=0, `gap`=0.
  - SYNC: on `flg_i` with a good period, `good_cnt`++, and go to LOCKED when `good_cnt`+1 == LOCK_CNT. On a bad period, `good_cnt`=0 and stay in SYNC. On timeout, go to IDLE.
  - LOCKED: any violation goes to ERR.
  - ERR: recovery is controlled by `BLINK_MON_STICKY_ERR_EN` (see Configuration).
- `err_pulse` fires only for violations detected in SYNC or LOCKED. In SYNC, `err_pulse` fires but `err` stays low.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE.
  - `locked`=0, `err`=0, `err_pulse`=0, `period`=0.
  - `gap`=0, `good_cnt`=0, `led_q`=0, `flg_q`=0.
- All outputs are registered. A violation detected at input sample cycle N gives `err_pulse` and state-output changes in cycle N+1.
- `locked` rises the cycle after the `flg_i` that completes the LOCK_CNT-th good period.
- `rst` mid-period discards all measurements. The first `flg_i` after reset only starts measurement and is never counted as a period.
- `flg_i` high for two consecutive cycles gives a measured period of 1, which is bad.

## Configuration
- `BLINK_MON_STICKY_ERR_EN` defined: ERR is absorbing; `err` stays 1 until `rst`. Later violations still pulse `err_pulse`.
- `BLINK_MON_STICKY_ERR_EN` undefined: in ERR, the next `flg_i` moves to SYNC with `good_cnt`=0 and `gap`=0. `err` falls the cycle after that `flg_i`, and relock requires LOCK_CNT good periods.

## Structure
- `blink_pkg` contains:
  - the state enum typedef (IDLE, SYNC, LOCKED, ERR);
  - the default CBITS constant, shared with the blinker;
  - a function computing P from CBITS.
- Sub-module `blink_gap_ctr`: the saturating gap counter with clear input, `sat` output, and `period` capture. The FSM and checks stay in the top level.

## Test plan
All scenarios use CBITS=4 (P=16, GMAX=31) and LOCK_CNT=2.
- Clean stream (`flg_i` every 16 cycles, `led_i` toggling the cycle after each `flg_i`) -> `locked`=1 the cycle after the 3rd `flg_i`; `period`=16; `err_pulse` never asserted.
- Locked, then `flg_i` arrives after 15 cycles -> one-cycle `err_pulse`; `err`=1, `locked`=0, `period`=15.
- Locked, `led_i` toggles 5 cycles after a `flg_i` -> `err_pulse`, ERR. Separately: locked, `led_i` fails to toggle after a `flg_i` -> ERR.
- Locked, `flg_i` held low for 40 cycles -> exactly one `err_pulse`, ERR; next `flg_i` gives `period`=31.
- ERR, then clean stream -> macro undefined: `err`=0 the cycle after the next `flg_i`, relock after 2 good periods. Macro defined: `err` stays 1.
- `rst` pulsed while locked, mid-period -> all outputs 0 in the same cycle; the first `flg_i` afterwards does not update `period`.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared definitions for the blink protocol: the blinker counter width
// shared with the blinker, the monitor state encoding and the period helper.
package blink_pkg;

  localparam int unsigned CBITS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    ERR    = 2'd3
  } blink_state_e;

  // Expected flg-to-flg distance for a blinker with a cbits-wide counter.
  function automatic int unsigned blink_period(input int unsigned cbits);
    return 32'd1 << cbits;
  endfunction

endpackage

// File: rtl/blink_gap_ctr.sv
// Saturating flg-to-flg gap counter with period capture.
// sat_o strobes in the cycle the counter steps into its maximum, so a
// timeout is flagged once and the counter then holds until the next clear.
module blink_gap_ctr
  import blink_pkg::*;
#(
  parameter int unsigned CBITS = CBITS_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_i,
  input  logic           cap_i,
  output logic [CBITS:0] gap_o,
  output logic           sat_o,
  output logic [CBITS:0] period_o
);

  localparam logic [CBITS:0] GMAX = '1;
  localparam logic [CBITS:0] ONE  = (CBITS+1)'(1);

  logic [CBITS:0] gap_q, gap_d;
  logic [CBITS:0] period_q, period_d;
  logic [CBITS:0] gap_inc;

  // Next gap value, next captured period and the saturation strobe.
  always_comb begin
    gap_inc  = (gap_q == GMAX) ? GMAX : gap_q + ONE;
    gap_d    = clr_i ? '0 : gap_inc;
    period_d = cap_i ? gap_inc : period_q;
    sat_o    = !clr_i && (gap_q == GMAX - ONE);
  end

  // Gap and period registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q    <= '0;
      period_q <= '0;
    end else begin
      gap_q    <= gap_d;
      period_q <= period_d;
    end
  end

  assign gap_o    = gap_q;
  assign period_o = period_q;

endmodule

// File: rtl/blink_monitor.sv
// Receive-side checker for the blink protocol: measures the flg period,
// checks led toggle placement and reports lock / error status.
// Build option: BLINK_MON_STICKY_ERR_EN makes ERR absorbing until rst.
module blink_monitor
  import blink_pkg::*;
#(
  parameter int unsigned CBITS    = CBITS_DEF,
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flg_i,
  input  logic           led_i,
  output logic           locked,
  output logic           err,
  output logic           err_pulse,
  output logic [CBITS:0] period
);

  localparam logic [CBITS:0] PM1       = (CBITS+1)'(blink_period(CBITS) - 1);
  localparam logic [3:0]     LOCK_LAST = 4'(LOCK_CNT - 1);

  blink_state_e   state_q, state_d;
  logic [3:0]     good_q, good_d;
  logic           led_q, flg_q;
  logic           pulse_d;
  logic           locked_q, err_q, pulse_q;
  logic [CBITS:0] gap;
  logic           sat;
  logic           per_good, bad_per, led_bad;

  blink_gap_ctr #(
    .CBITS (CBITS)
  ) u_gap (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (flg_i),
    .cap_i    (flg_i && (state_q != IDLE)),
    .gap_o    (gap),
    .sat_o    (sat),
    .period_o (period)
  );

  // Next state, good-period count and violation strobe.
  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    pulse_d  = 1'b0;
    per_good = (gap == PM1);
    bad_per  = flg_i && !per_good;
    // A led change is legal only right after flg; right after flg it is mandatory.
    led_bad  = ((led_i != led_q) != flg_q);
    unique case (state_q)
      IDLE: begin
        if (flg_i) begin
          state_d = SYNC;
          good_d  = '0;
        end
      end
      SYNC: begin
        if (flg_i) begin
          if (per_good) begin
            good_d = good_q + 4'd1;
            if (good_q == LOCK_LAST) state_d = LOCKED;
          end else begin
            good_d  = '0;
            pulse_d = 1'b1;
          end
        end else if (sat) begin
          state_d = IDLE;
          pulse_d = 1'b1;
        end
      end
      LOCKED: begin
        if (bad_per || led_bad || sat) begin
          state_d = ERR;
          pulse_d = 1'b1;
        end
      end
      ERR: begin
`ifdef BLINK_MON_STICKY_ERR_EN
        pulse_d = bad_per || sat;
`else
        if (flg_i) begin
          state_d = SYNC;
          good_d  = '0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State, history and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      good_q   <= '0;
      led_q    <= 1'b0;
      flg_q    <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      led_q    <= led_i;
      flg_q    <= flg_i;
      locked_q <= (state_d == LOCKED);
      err_q    <= (state_d == ERR);
      pulse_q  <= pulse_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign err_pulse = pulse_q;

endmodule
